// File: rtl/snd_cmd_queue.sv
// snd_cmd_queue: sound-command FIFO between the main CPU and the sound Z80.
// Commands are pushed on rising edges of sndstart and popped at the end of
// each Z80 read of the command latch. An NMI is raised whenever a new head
// command becomes visible, and a free-running frame timer raises periodic IRQs.
// Optional build macro SNDQ_OVERWRITE_EN: a push while full replaces the
// newest entry instead of being dropped. Overflow is flagged in both builds.
module snd_cmd_queue #(
  parameter int DATA_W        = 8,
  parameter int DEPTH_LOG2    = 2,
  parameter int IRQ_PERIOD    = 66667,
  parameter int IRQ_PER_FRAME = 2
) (
  input  logic                  clk48M,
  input  logic                  reset,
  input  logic                  clk_en,
  input  logic [DATA_W-1:0]     sndno,
  input  logic                  sndstart,
  input  logic                  cpu_com_rd,
  output logic [DATA_W-1:0]     comlatch,
  output logic                  cpu_nmi,
  input  logic                  cpu_nmia,
  output logic                  cpu_irq,
  input  logic                  cpu_irqa,
  output logic [DEPTH_LOG2:0]   fifo_count,
  output logic                  overflow
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PTR_W = (DEPTH_LOG2 > 0) ? DEPTH_LOG2 : 1;
  localparam int CNT_W = DEPTH_LOG2 + 1;
  localparam int TMR_W = (IRQ_PERIOD > 1) ? $clog2(IRQ_PERIOD) : 1;
  localparam int STEP  = IRQ_PERIOD / IRQ_PER_FRAME;

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(IRQ_PERIOD - 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr, rd_nxt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic [TMR_W-1:0]  timercnt;
  logic              psndstart, prd;
  logic              push, pop, is_empty, is_full;
  logic              do_push, do_pop, push_full;
  logic              nmi_set, irq_hit, ow_head;
  logic [DATA_W-1:0] head_nxt;
`ifdef SNDQ_OVERWRITE_EN
  logic [PTR_W-1:0]  ow_ptr;
`endif

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // Edge decode, queue bookkeeping and next head value with write forwarding.
  always_comb begin
    push      = sndstart & ~psndstart;
    pop       = prd & ~cpu_com_rd;
    is_empty  = (fifo_count == '0);
    is_full   = (fifo_count == FULL_CNT);
    do_pop    = pop & ~is_empty;
    // a simultaneous pop frees a slot first, so a full queue still accepts
    do_push   = push & (~is_full | do_pop);
    push_full = push & is_full & ~do_pop;
    rd_nxt    = do_pop ? next_ptr(rd_ptr) : rd_ptr;
    cnt_nxt   = fifo_count;
    if (do_push && !do_pop)
      cnt_nxt = fifo_count + 1'b1;
    else if (do_pop && !do_push)
      cnt_nxt = fifo_count - 1'b1;
    head_nxt  = mem[rd_nxt];
    if (do_push && (wr_ptr == rd_nxt))
      head_nxt = sndno;
    ow_head   = 1'b0;
`ifdef SNDQ_OVERWRITE_EN
    ow_ptr    = (wr_ptr == '0) ? LAST_PTR : wr_ptr - 1'b1;
    // only possible with a single-entry queue, where the newest is the head
    if (push_full && (ow_ptr == rd_nxt)) begin
      head_nxt = sndno;
      ow_head  = 1'b1;
    end
`endif
    nmi_set   = (do_push & is_empty) | (do_pop & (cnt_nxt != '0)) | ow_head;
  end

  // Frame timer compare: IRQ at the end of each equal slice of the frame.
  always_comb begin
    irq_hit = 1'b0;
    for (int k = 1; k <= IRQ_PER_FRAME; k++)
      if (timercnt == TMR_W'(k * STEP - 1))
        irq_hit = 1'b1;
  end

  // Control registers: pointers, count, latch, interrupt requests, timer.
  always_ff @(posedge clk48M) begin
    if (reset) begin
      psndstart  <= 1'b0;
      prd        <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      comlatch   <= '0;
      overflow   <= 1'b0;
      cpu_nmi    <= 1'b0;
      cpu_irq    <= 1'b0;
      timercnt   <= '0;
    end else if (clk_en) begin
      psndstart  <= sndstart;
      prd        <= cpu_com_rd;
      rd_ptr     <= rd_nxt;
      if (do_push)
        wr_ptr <= next_ptr(wr_ptr);
      fifo_count <= cnt_nxt;
      // an empty queue keeps showing the last command
      if (cnt_nxt != '0)
        comlatch <= head_nxt;
      if (push_full)
        overflow <= 1'b1;
      cpu_nmi    <= nmi_set | (cpu_nmi & ~cpu_nmia);
      timercnt   <= (timercnt == TMR_LAST) ? '0 : timercnt + 1'b1;
      cpu_irq    <= irq_hit | (cpu_irq & ~cpu_irqa);
    end
  end

  // Command storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clk48M) begin
    if (clk_en && !reset) begin
      if (do_push)
        mem[wr_ptr] <= sndno;
`ifdef SNDQ_OVERWRITE_EN
      else if (push_full)
        mem[ow_ptr] <= sndno;
`endif
    end
  end

endmodule

// File: tb/tb_snd_cmd_queue.sv
// Testbench for snd_cmd_queue: directed scenarios plus randomized traffic
// checked against a queue-based reference model.
module tb_snd_cmd_queue;

  localparam int DL2   = 2;
  localparam int DEPTH = 1 << DL2;
  localparam int P     = 600;
  localparam int NIRQ  = 2;
  localparam int STEP  = P / NIRQ;

  logic           clk48M = 1'b0;
  logic           reset = 1'b0, clk_en = 1'b0;
  logic [7:0]     sndno = '0;
  logic           sndstart = 1'b0, cpu_com_rd = 1'b0;
  logic           cpu_nmia = 1'b0, cpu_irqa = 1'b0;
  logic [7:0]     comlatch;
  logic           cpu_nmi, cpu_irq, overflow;
  logic [DL2:0]   fifo_count;

  int tests = 0;
  int fails = 0;

  // reference model state
  logic [7:0] q[$];
  logic [7:0] m_latch;
  logic       m_nmi, m_irq, m_ovf, m_psnd, m_prd;
  int         m_t;

  snd_cmd_queue #(.DATA_W(8), .DEPTH_LOG2(DL2), .IRQ_PERIOD(P), .IRQ_PER_FRAME(NIRQ)) dut (
    .clk48M(clk48M), .reset(reset), .clk_en(clk_en), .sndno(sndno),
    .sndstart(sndstart), .cpu_com_rd(cpu_com_rd), .comlatch(comlatch),
    .cpu_nmi(cpu_nmi), .cpu_nmia(cpu_nmia), .cpu_irq(cpu_irq),
    .cpu_irqa(cpu_irqa), .fifo_count(fifo_count), .overflow(overflow)
  );

  always #5 clk48M = ~clk48M;

  task automatic model_reset();
    q.delete();
    m_latch = '0; m_nmi = 0; m_irq = 0; m_ovf = 0; m_psnd = 0; m_prd = 0; m_t = 0;
  endtask

  task automatic model_step(input logic ss, input logic [7:0] no, input logic rd,
                            input logic na, input logic ia);
    logic push, pop, newhead, hit;
    int c;
    push = ss && !m_psnd;
    pop  = m_prd && !rd;
    newhead = 0;
    if (pop && q.size() > 0) begin
      void'(q.pop_front());
      if (q.size() > 0) newhead = 1;
    end
    if (push) begin
      if (q.size() < DEPTH) begin
        if (q.size() == 0) newhead = 1;
        q.push_back(no);
      end else begin
        m_ovf = 1;
`ifdef SNDQ_OVERWRITE_EN
        q[q.size()-1] = no;
        if (DEPTH == 1) newhead = 1;
`endif
      end
    end
    if (q.size() > 0) m_latch = q[0];
    m_nmi = newhead ? 1'b1 : (na ? 1'b0 : m_nmi);
    c   = m_t % P;
    hit = ((c + 1) % STEP == 0) && ((c + 1) / STEP <= NIRQ);
    m_irq = hit ? 1'b1 : (ia ? 1'b0 : m_irq);
    m_t++;
    m_psnd = ss;
    m_prd  = rd;
  endtask

  task automatic tick(input logic en, input logic ss, input logic [7:0] no,
                      input logic rd, input logic na, input logic ia);
    @(negedge clk48M);
    clk_en = en; sndstart = ss; sndno = no; cpu_com_rd = rd; cpu_nmia = na; cpu_irqa = ia;
    @(posedge clk48M);
    #1;
    if (en) model_step(ss, no, rd, na, ia);
  endtask

  task automatic do_reset();
    @(negedge clk48M);
    reset = 1; clk_en = 0; sndstart = 0; cpu_com_rd = 0; cpu_nmia = 0; cpu_irqa = 0;
    @(posedge clk48M);
    #1;
    reset = 0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if (comlatch !== 8'h00) begin fails++; $display("FAIL reset_comlatch: got %0h want 0", comlatch); end
    tests++; if (fifo_count !== '0) begin fails++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
    tests++; if (cpu_nmi !== 1'b0) begin fails++; $display("FAIL reset_nmi: got %b want 0", cpu_nmi); end
    tests++; if (cpu_irq !== 1'b0) begin fails++; $display("FAIL reset_irq: got %b want 0", cpu_irq); end
    tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL reset_overflow: got %b want 0", overflow); end
  endtask

  task automatic test_single_push();
    do_reset();
    tick(1, 1, 8'h42, 0, 0, 0);
    tests++; if (comlatch !== 8'h42) begin fails++; $display("FAIL single_latch: got %0h want 42", comlatch); end
    tests++; if (cpu_nmi !== 1'b1) begin fails++; $display("FAIL single_nmi: got %b want 1", cpu_nmi); end
    tests++; if (fifo_count !== 3'd1) begin fails++; $display("FAIL single_count: got %0d want 1", fifo_count); end
    tick(1, 0, 8'h42, 0, 1, 0);
    tests++; if (cpu_nmi !== 1'b0) begin fails++; $display("FAIL single_nmia: got %b want 0", cpu_nmi); end
    tick(1, 0, 8'h42, 1, 0, 0);
    tick(1, 0, 8'h42, 0, 0, 0);
    tests++; if (fifo_count !== 3'd0) begin fails++; $display("FAIL single_pop_count: got %0d want 0", fifo_count); end
    tests++; if (comlatch !== 8'h42) begin fails++; $display("FAIL single_pop_latch: got %0h want 42", comlatch); end
    tests++; if (cpu_nmi !== 1'b0) begin fails++; $display("FAIL single_pop_nmi: got %b want 0", cpu_nmi); end
  endtask

  task automatic test_fill_drain();
    logic [7:0] exp_seq [4];
    exp_seq[0] = 8'h01; exp_seq[1] = 8'h02; exp_seq[2] = 8'h03;
`ifdef SNDQ_OVERWRITE_EN
    exp_seq[3] = 8'h05;
`else
    exp_seq[3] = 8'h04;
`endif
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      tick(1, 1, 8'(i), 0, 0, 0);
      tick(1, 0, 8'(i), 0, 0, 0);
    end
    tests++; if (fifo_count !== 3'd4) begin fails++; $display("FAIL fill_count: got %0d want 4", fifo_count); end
    tests++; if (comlatch !== 8'h01) begin fails++; $display("FAIL fill_latch: got %0h want 01", comlatch); end
    tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL fill_overflow: got %b want 0", overflow); end
    tick(1, 1, 8'h05, 0, 0, 0);
    tick(1, 0, 8'h05, 0, 0, 0);
    tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_flag: got %b want 1", overflow); end
    tests++; if (fifo_count !== 3'd4) begin fails++; $display("FAIL ovf_count: got %0d want 4", fifo_count); end
    for (int j = 0; j < 4; j++) begin
      tick(1, 0, 8'h00, 1, 1, 0);
      tick(1, 0, 8'h00, 0, 0, 0);
      tests++;
      if (fifo_count !== 3'(3 - j)) begin fails++; $display("FAIL drain_count[%0d]: got %0d want %0d", j, fifo_count, 3 - j); end
      tests++;
      if (cpu_nmi !== (j < 3)) begin fails++; $display("FAIL drain_nmi[%0d]: got %b want %b", j, cpu_nmi, j < 3); end
      tests++;
      if (comlatch !== exp_seq[(j < 3) ? j + 1 : 3]) begin
        fails++; $display("FAIL drain_latch[%0d]: got %0h want %0h", j, comlatch, exp_seq[(j < 3) ? j + 1 : 3]);
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      tick(1, 1, 8'(8'h10 + i), 0, 0, 0);
      tick(1, 0, 8'h00, 0, 0, 0);
    end
    tick(1, 0, 8'h00, 1, 1, 0);
    tick(1, 1, 8'hAA, 0, 0, 0);
    tests++; if (fifo_count !== 3'd4) begin fails++; $display("FAIL b2b_full_count: got %0d want 4", fifo_count); end
    tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL b2b_full_overflow: got %b want 0", overflow); end
    tests++; if (comlatch !== 8'h11) begin fails++; $display("FAIL b2b_full_latch: got %0h want 11", comlatch); end
    tests++; if (cpu_nmi !== 1'b1) begin fails++; $display("FAIL b2b_full_nmi: got %b want 1", cpu_nmi); end
    for (int j = 0; j < 4; j++) begin
      tick(1, 0, 8'h00, 1, 0, 0);
      tick(1, 0, 8'h00, 0, 0, 0);
    end
    tests++; if (comlatch !== 8'hAA) begin fails++; $display("FAIL b2b_drain_latch: got %0h want aa", comlatch); end
    tick(1, 0, 8'h00, 1, 1, 0);
    tick(1, 1, 8'hBB, 0, 0, 0);
    tests++; if (fifo_count !== 3'd1) begin fails++; $display("FAIL b2b_empty_count: got %0d want 1", fifo_count); end
    tests++; if (comlatch !== 8'hBB) begin fails++; $display("FAIL b2b_empty_latch: got %0h want bb", comlatch); end
    tests++; if (cpu_nmi !== 1'b1) begin fails++; $display("FAIL b2b_empty_nmi: got %b want 1", cpu_nmi); end
  endtask

  task automatic test_irq();
    logic ia, exp_irq;
    int bad;
    do_reset();
    bad = 0;
    for (int i = 0; i < 2 * P; i++) begin
      // ack on the setting tick (set must win) and again on the following tick
      ia = ((i + 1) % STEP == 0) || (i > 0 && i % STEP == 0);
      tick(1, 0, 8'h00, 0, 0, ia);
      exp_irq = ((i + 1) % STEP == 0);
      tests++;
      if (cpu_irq !== exp_irq) begin
        fails++;
        if (bad < 8) $display("FAIL irq_tick[%0d]: got %b want %b", i + 1, cpu_irq, exp_irq);
        bad++;
      end
    end
    // clk_en low must freeze the timer and the request
    tick(1, 0, 8'h00, 0, 0, 1);
    for (int i = 0; i < STEP + 5; i++) tick(0, 0, 8'h00, 0, 0, 0);
    tests++; if (cpu_irq !== 1'b0) begin fails++; $display("FAIL irq_gated: got %b want 0", cpu_irq); end
  endtask

  task automatic test_reset_mid();
    int guard;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      tick(1, 1, 8'(8'h30 + i), 0, 0, 0);
      tick(1, 0, 8'h00, 0, 0, 0);
    end
    guard = 0;
    while (cpu_irq !== 1'b1 && guard < P) begin
      tick(1, 0, 8'h00, 0, 0, 0);
      guard++;
    end
    tests++; if (guard >= P) begin fails++; $display("FAIL rstmid_irq_timeout: got irq %b want 1", cpu_irq); end
    tests++; if (fifo_count !== 3'd3) begin fails++; $display("FAIL rstmid_pre_count: got %0d want 3", fifo_count); end
    tests++; if (cpu_nmi !== 1'b1) begin fails++; $display("FAIL rstmid_pre_nmi: got %b want 1", cpu_nmi); end
    do_reset();
    tests++; if (fifo_count !== 3'd0) begin fails++; $display("FAIL rstmid_count: got %0d want 0", fifo_count); end
    tests++; if (comlatch !== 8'h00) begin fails++; $display("FAIL rstmid_latch: got %0h want 0", comlatch); end
    tests++; if (cpu_nmi !== 1'b0 || cpu_irq !== 1'b0 || overflow !== 1'b0) begin
      fails++; $display("FAIL rstmid_flags: got nmi=%b irq=%b ovf=%b want 0", cpu_nmi, cpu_irq, overflow);
    end
    for (int i = 0; i < STEP - 1; i++) tick(1, 0, 8'h00, 0, 0, 0);
    tests++; if (cpu_irq !== 1'b0) begin fails++; $display("FAIL rstmid_timer_early: got %b want 0", cpu_irq); end
    tick(1, 0, 8'h00, 0, 0, 0);
    tests++; if (cpu_irq !== 1'b1) begin fails++; $display("FAIL rstmid_timer_restart: got %b want 1", cpu_irq); end
  endtask

  task automatic test_random();
    logic en, ss, rd, na, ia;
    logic [7:0] no;
    int bad;
    bad = 0;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (i % 750 == 749) begin
        do_reset();
      end else begin
        en = ($urandom_range(0, 4) != 0);
        ss = ($urandom_range(0, 2) == 0);
        no = 8'($urandom);
        rd = ($urandom_range(0, 2) == 0);
        na = ($urandom_range(0, 3) == 0);
        ia = ($urandom_range(0, 3) == 0);
        tick(en, ss, no, rd, na, ia);
      end
      tests++;
      if (comlatch !== m_latch || fifo_count !== 3'(q.size()) || cpu_nmi !== m_nmi ||
          cpu_irq !== m_irq || overflow !== m_ovf) begin
        fails++;
        if (bad < 8)
          $display("FAIL rand[%0d]: got latch=%0h cnt=%0d nmi=%b irq=%b ovf=%b want latch=%0h cnt=%0d nmi=%b irq=%b ovf=%b",
                   i, comlatch, fifo_count, cpu_nmi, cpu_irq, overflow,
                   m_latch, q.size(), m_nmi, m_irq, m_ovf);
        bad++;
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_push();
    test_fill_drain();
    test_back_to_back();
    test_irq();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
